// File: rtl/ahbl_arbiter.sv
// rtl/ahbl_arbiter.sv - N-master to 1-slave AHB-Lite arbiter with per-port address buffering
//
// Lets several AHB-Lite masters share one downstream AHB-Lite port. Port 0 has
// the highest priority. A master that loses arbitration has its address phase
// captured in a one-entry buffer and is held off through src_hready_resp until
// the data phase of that buffered transfer completes downstream.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   src_*             N_PORTS upstream slave interfaces, port i packed at [i*W +: W]
//   src_hready        per-port bus hready (normally tied to src_hready_resp)
//   src_hready_resp   per-port data-phase ready, src_hresp per-port error
//   src_hrdata        broadcast of dst_hrdata
//   dst_*             downstream master interface (granted address phase,
//                     write data of the current data-phase owner)
//   dst_hready        mirrors dst_hready_resp
module ahbl_arbiter #(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        src_hready,
  output logic [N_PORTS-1:0]        src_hready_resp,
  output logic [N_PORTS-1:0]        src_hresp,
  input  logic [N_PORTS*W_ADDR-1:0] src_haddr,
  input  logic [N_PORTS-1:0]        src_hwrite,
  input  logic [N_PORTS*2-1:0]      src_htrans,
  input  logic [N_PORTS*3-1:0]      src_hsize,
  input  logic [N_PORTS*3-1:0]      src_hburst,
  input  logic [N_PORTS*4-1:0]      src_hprot,
  input  logic [N_PORTS-1:0]        src_hmastlock,
  input  logic [N_PORTS*W_DATA-1:0] src_hwdata,
  output logic [N_PORTS*W_DATA-1:0] src_hrdata,
  output logic                      dst_hready,
  input  logic                      dst_hready_resp,
  input  logic                      dst_hresp,
  output logic [W_ADDR-1:0]         dst_haddr,
  output logic                      dst_hwrite,
  output logic [1:0]                dst_htrans,
  output logic [2:0]                dst_hsize,
  output logic [2:0]                dst_hburst,
  output logic [3:0]                dst_hprot,
  output logic                      dst_hmastlock,
  output logic [W_DATA-1:0]         dst_hwdata,
  input  logic [W_DATA-1:0]         dst_hrdata
);

  localparam int W_PORT = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  // Buffered address phases, one entry per port
  logic [N_PORTS-1:0] buf_valid;
  logic [W_ADDR-1:0]  buf_haddr     [N_PORTS];
  logic               buf_hwrite    [N_PORTS];
  logic [1:0]         buf_htrans    [N_PORTS];
  logic [2:0]         buf_hsize     [N_PORTS];
  logic [2:0]         buf_hburst    [N_PORTS];
  logic [3:0]         buf_hprot     [N_PORTS];
  logic               buf_hmastlock [N_PORTS];

  logic [N_PORTS-1:0] stalled;
  logic               dp_valid;
  logic [W_PORT-1:0]  dp_port;
  logic               lock_valid;
  logic [W_PORT-1:0]  lock_owner;

  logic [N_PORTS-1:0] blocked, fresh, req, take_buf;
  logic               gnt_valid;
  logic [W_PORT-1:0]  gnt_port;

  logic [W_ADDR-1:0]  g_haddr;
  logic               g_hwrite;
  logic [1:0]         g_htrans;
  logic [2:0]         g_hsize;
  logic [2:0]         g_hburst;
  logic [3:0]         g_hprot;
  logic               g_hmastlock;

  // A stalled port becomes free to issue again in the cycle its buffered
  // data phase is on the bus: the master sees hready from the slave then and
  // may present its next address phase in that same cycle.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      blocked[i] = stalled[i] & ~(dp_valid & (dp_port == W_PORT'(i)));
      fresh[i]   = src_hready[i] & src_htrans[2*i+1] & ~blocked[i];
      req[i]     = buf_valid[i] | fresh[i];
    end
  end

  // Fixed priority, lowest index wins; an active lock pins the grant to its
  // owner even when the owner shows IDLE/BUSY. Reset forces no grant at once.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_port  = '0;
    if (lock_valid) begin
      gnt_valid = 1'b1;
      gnt_port  = lock_owner;
    end else begin
      for (int i = N_PORTS - 1; i >= 0; i--) begin
        if (req[i]) begin
          gnt_valid = 1'b1;
          gnt_port  = W_PORT'(i);
        end
      end
    end
    if (rst) gnt_valid = 1'b0;
  end

  always_comb begin
    g_haddr     = src_haddr[int'(gnt_port)*W_ADDR +: W_ADDR];
    g_hwrite    = src_hwrite[gnt_port];
    g_htrans    = src_htrans[int'(gnt_port)*2 +: 2];
    g_hsize     = src_hsize[int'(gnt_port)*3 +: 3];
    g_hburst    = src_hburst[int'(gnt_port)*3 +: 3];
    g_hprot     = src_hprot[int'(gnt_port)*4 +: 4];
    g_hmastlock = src_hmastlock[gnt_port];
    if (buf_valid[gnt_port]) begin
      g_haddr     = buf_haddr[gnt_port];
      g_hwrite    = buf_hwrite[gnt_port];
      g_htrans    = buf_htrans[gnt_port];
      g_hsize     = buf_hsize[gnt_port];
      g_hburst    = buf_hburst[gnt_port];
      g_hprot     = buf_hprot[gnt_port];
      g_hmastlock = buf_hmastlock[gnt_port];
    end
  end

  always_comb begin
    dst_haddr     = '0;
    dst_hwrite    = 1'b0;
    dst_htrans    = 2'b00;
    dst_hsize     = 3'b000;
    dst_hburst    = 3'b000;
    dst_hprot     = 4'b0000;
    dst_hmastlock = 1'b0;
    if (gnt_valid) begin
      dst_haddr     = g_haddr;
      dst_hwrite    = g_hwrite;
      dst_htrans    = g_htrans;
      dst_hsize     = g_hsize;
      dst_hburst    = g_hburst;
      dst_hprot     = g_hprot;
      dst_hmastlock = g_hmastlock;
    end
  end

  assign dst_hready = dst_hready_resp;
  assign dst_hwdata = src_hwdata[int'(dp_port)*W_DATA +: W_DATA];
  assign src_hrdata = {N_PORTS{dst_hrdata}};

  // Data-phase owner sees the slave response; that wins over stalled so a
  // buffered transfer's own data phase completes normally.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      if (dp_valid && dp_port == W_PORT'(i)) begin
        src_hready_resp[i] = dst_hready_resp;
        src_hresp[i]       = dst_hresp;
      end else begin
        src_hready_resp[i] = ~stalled[i];
        src_hresp[i]       = 1'b0;
      end
      take_buf[i] = fresh[i] & ~buf_valid[i] &
                    ~(gnt_valid & (gnt_port == W_PORT'(i)) & dst_hready_resp);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid  <= '0;
      stalled    <= '0;
      dp_valid   <= 1'b0;
      dp_port    <= '0;
      lock_valid <= 1'b0;
      lock_owner <= '0;
      for (int i = 0; i < N_PORTS; i++) begin
        buf_haddr[i]     <= '0;
        buf_hwrite[i]    <= 1'b0;
        buf_htrans[i]    <= 2'b00;
        buf_hsize[i]     <= 3'b000;
        buf_hburst[i]    <= 3'b000;
        buf_hprot[i]     <= 4'b0000;
        buf_hmastlock[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (take_buf[i]) begin
          buf_haddr[i]     <= src_haddr[i*W_ADDR +: W_ADDR];
          buf_hwrite[i]    <= src_hwrite[i];
          buf_htrans[i]    <= src_htrans[i*2 +: 2];
          buf_hsize[i]     <= src_hsize[i*3 +: 3];
          buf_hburst[i]    <= src_hburst[i*3 +: 3];
          buf_hprot[i]     <= src_hprot[i*4 +: 4];
          buf_hmastlock[i] <= src_hmastlock[i];
          buf_valid[i]     <= 1'b1;
          stalled[i]       <= 1'b1;
        end else begin
          if (gnt_valid && gnt_port == W_PORT'(i) && dst_hready_resp)
            buf_valid[i] <= 1'b0;
          if (dp_valid && dp_port == W_PORT'(i) && dst_hready_resp)
            stalled[i] <= 1'b0;
        end
      end
      if (dst_hready_resp) begin
        dp_port  <= gnt_port;
        dp_valid <= gnt_valid & g_htrans[1];
        if (lock_valid) begin
          if (!g_hmastlock || g_htrans == 2'b00) lock_valid <= 1'b0;
        end else if (gnt_valid && g_htrans[1] && g_hmastlock) begin
          lock_valid <= 1'b1;
          lock_owner <= gnt_port;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahbl_arbiter.sv
// tb/tb_ahbl_arbiter.sv - directed self-checking bench for ahbl_arbiter with a small SRAM slave
module tb_ahbl_arbiter;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] NSEQ = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  src_hready;
  logic [1:0]  src_hready_resp;
  logic [1:0]  src_hresp;
  logic [63:0] src_haddr = '0;
  logic [1:0]  src_hwrite = '0;
  logic [3:0]  src_htrans = '0;
  logic [5:0]  src_hsize = '0;
  logic [5:0]  src_hburst = '0;
  logic [7:0]  src_hprot = '0;
  logic [1:0]  src_hmastlock = '0;
  logic [63:0] src_hwdata = '0;
  logic [63:0] src_hrdata;
  logic        dst_hready;
  logic        dst_hready_resp;
  logic        dst_hresp;
  logic [31:0] dst_haddr;
  logic        dst_hwrite;
  logic [1:0]  dst_htrans;
  logic [2:0]  dst_hsize;
  logic [2:0]  dst_hburst;
  logic [3:0]  dst_hprot;
  logic        dst_hmastlock;
  logic [31:0] dst_hwdata;
  logic [31:0] dst_hrdata;

  int n_checks = 0;
  int n_errors = 0;

  assign src_hready = src_hready_resp;

  ahbl_arbiter #(.N_PORTS(2), .W_ADDR(32), .W_DATA(32)) dut (
    .clk(clk), .rst(rst),
    .src_hready(src_hready), .src_hready_resp(src_hready_resp), .src_hresp(src_hresp),
    .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
    .src_hsize(src_hsize), .src_hburst(src_hburst), .src_hprot(src_hprot),
    .src_hmastlock(src_hmastlock), .src_hwdata(src_hwdata), .src_hrdata(src_hrdata),
    .dst_hready(dst_hready), .dst_hready_resp(dst_hready_resp), .dst_hresp(dst_hresp),
    .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
    .dst_hsize(dst_hsize), .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
    .dst_hmastlock(dst_hmastlock), .dst_hwdata(dst_hwdata), .dst_hrdata(dst_hrdata)
  );

  always #5 clk = ~clk;

  // Slave: 256-word SRAM, optional 2 wait states or 2-cycle ERROR by address
  logic [31:0] mem [0:255];
  logic        s_valid, s_write, s_err, s_errph;
  logic [31:0] s_addr;
  int          s_wait;
  logic        cfg_wait_en = 1'b0, cfg_err_en = 1'b0;
  logic [31:0] cfg_wait_addr = 32'h300, cfg_err_addr = 32'h3f0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid <= 1'b0; s_write <= 1'b0; s_err <= 1'b0; s_errph <= 1'b0;
      s_addr <= '0; s_wait <= 0;
      for (int k = 0; k < 256; k++) mem[k] <= '0;
    end else if (s_valid && s_wait > 0) begin
      s_wait <= s_wait - 1;
    end else if (s_valid && s_err && !s_errph) begin
      s_errph <= 1'b1;
    end else begin
      if (s_valid && s_write && !s_err) mem[s_addr[9:2]] <= dst_hwdata;
      s_valid <= dst_htrans[1];
      s_addr  <= dst_haddr;
      s_write <= dst_hwrite;
      s_wait  <= (cfg_wait_en && dst_haddr == cfg_wait_addr) ? 2 : 0;
      s_err   <= cfg_err_en && dst_haddr == cfg_err_addr;
      s_errph <= 1'b0;
    end
  end

  always_comb begin
    dst_hready_resp = 1'b1;
    dst_hresp = 1'b0;
    if (s_valid) begin
      if (s_wait > 0) dst_hready_resp = 1'b0;
      else if (s_err) begin
        dst_hresp = 1'b1;
        dst_hready_resp = s_errph;
      end
    end
  end
  assign dst_hrdata = mem[s_addr[9:2]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ap(input int p, input logic [1:0] tr, input logic wr,
                        input logic [31:0] a, input logic lk);
    src_htrans[p*2 +: 2]  = tr;
    src_hwrite[p]         = wr;
    src_haddr[p*32 +: 32] = a;
    src_hmastlock[p]      = lk;
    src_hsize[p*3 +: 3]   = 3'b010;
    src_hburst[p*3 +: 3]  = 3'b000;
    src_hprot[p*4 +: 4]   = 4'b0011;
  endtask

  task automatic set_wd(input int p, input logic [31:0] d);
    src_hwdata[p*32 +: 32] = d;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_hready_resp", src_hready_resp, 2'b11);
    check("rst_hresp", src_hresp, 2'b00);
    check("rst_htrans", dst_htrans, IDLE);
    check("rst_haddr", dst_haddr, 32'h0);
    rst = 1'b0;

    // Port 0 alone: write then read 0x40
    set_ap(0, NSEQ, 1'b1, 32'h40, 1'b0); #1;
    check("p0_wr_addr", dst_haddr, 32'h40);
    check("p0_wr_trans", dst_htrans, NSEQ);
    check("p0_wr_hsize", dst_hsize, 3'b010);
    check("p0_wr_rdy", src_hready_resp[0], 1'b1);
    tick();
    set_wd(0, 32'hdeadbeef); set_ap(0, NSEQ, 1'b0, 32'h40, 1'b0); #1;
    check("p0_wdata", dst_hwdata, 32'hdeadbeef);
    check("p0_rd_rdy", src_hready_resp[0], 1'b1);
    check("p0_rd_write", dst_hwrite, 1'b0);
    tick();
    set_ap(0, IDLE, 1'b0, 32'h0, 1'b0); #1;
    check("p0_rdata", src_hrdata[31:0], 32'hdeadbeef);
    check("p0_rd_done_rdy", src_hready_resp[0], 1'b1);
    tick();

    // Simultaneous NSEQ writes: port 0 passes through, port 1 buffered one cycle
    set_ap(0, NSEQ, 1'b1, 32'h0, 1'b0); set_ap(1, NSEQ, 1'b1, 32'h100, 1'b0); #1;
    check("sim_addr0", dst_haddr, 32'h0);
    check("sim_rdy_a", src_hready_resp, 2'b11);
    tick();
    set_wd(0, 32'h11111111); set_ap(0, IDLE, 1'b0, 32'h0, 1'b0);
    set_wd(1, 32'h22222222); set_ap(1, IDLE, 1'b0, 32'h0, 1'b0); #1;
    check("sim_addr1_buf", dst_haddr, 32'h100);
    check("sim_trans1_buf", dst_htrans, NSEQ);
    check("sim_rdy_b", src_hready_resp, 2'b01);
    check("sim_wdata0", dst_hwdata, 32'h11111111);
    tick();
    set_ap(0, NSEQ, 1'b0, 32'h0, 1'b0); #1;
    check("sim_rdy_c", src_hready_resp, 2'b11);
    check("sim_wdata1", dst_hwdata, 32'h22222222);
    tick();
    set_ap(0, IDLE, 1'b0, 32'h0, 1'b0); set_ap(1, NSEQ, 1'b0, 32'h100, 1'b0); #1;
    check("sim_rdata0", src_hrdata[31:0], 32'h11111111);
    tick();
    set_ap(1, IDLE, 1'b0, 32'h0, 1'b0); #1;
    check("sim_rdata1", src_hrdata[63:32], 32'h22222222);
    check("sim_rdy_e", src_hready_resp[1], 1'b1);
    tick();

    // Locked sequence from port 1 while port 0 requests
    set_ap(1, NSEQ, 1'b1, 32'h200, 1'b1); #1;
    check("lk_addr0", dst_haddr, 32'h200);
    check("lk_mastlock", dst_hmastlock, 1'b1);
    tick();
    set_wd(1, 32'ha0); set_ap(1, NSEQ, 1'b1, 32'h204, 1'b1);
    set_ap(0, NSEQ, 1'b0, 32'h40, 1'b0); #1;
    check("lk_addr1", dst_haddr, 32'h204);
    check("lk_wdata0", dst_hwdata, 32'ha0);
    tick();
    set_wd(1, 32'ha1); set_ap(1, NSEQ, 1'b1, 32'h208, 1'b1);
    set_ap(0, IDLE, 1'b0, 32'h0, 1'b0); #1;
    check("lk_addr2", dst_haddr, 32'h208);
    check("lk_p0_stall_c", src_hready_resp[0], 1'b0);
    tick();
    set_wd(1, 32'ha2); set_ap(1, IDLE, 1'b0, 32'h0, 1'b0); #1;
    check("lk_idle_fwd", dst_htrans, IDLE);
    check("lk_p0_stall_d", src_hready_resp[0], 1'b0);
    tick();
    #1;
    check("lk_p0_addr", dst_haddr, 32'h40);
    check("lk_p0_trans", dst_htrans, NSEQ);
    check("lk_p0_stall_e", src_hready_resp[0], 1'b0);
    tick();
    #1;
    check("lk_p0_rdy_f", src_hready_resp[0], 1'b1);
    check("lk_p0_rdata", src_hrdata[31:0], 32'hdeadbeef);
    tick();
    check("lk_mem0", mem[8'h80], 32'ha0);
    check("lk_mem1", mem[8'h81], 32'ha1);
    check("lk_mem2", mem[8'h82], 32'ha2);

    // Two wait states on port 0 while port 1 requests
    cfg_wait_en = 1'b1;
    set_ap(0, NSEQ, 1'b1, 32'h300, 1'b0); #1;
    tick();
    set_wd(0, 32'h33); set_ap(0, IDLE, 1'b0, 32'h0, 1'b0);
    set_ap(1, NSEQ, 1'b1, 32'h304, 1'b0); #1;
    check("ws_dst_rdy_b", dst_hready_resp, 1'b0);
    check("ws_rdy_b", src_hready_resp, 2'b10);
    check("ws_addr_b", dst_haddr, 32'h304);
    tick();
    set_wd(1, 32'h34); set_ap(1, IDLE, 1'b0, 32'h0, 1'b0); #1;
    check("ws_addr_c", dst_haddr, 32'h304);
    check("ws_rdy_c", src_hready_resp, 2'b00);
    tick();
    #1;
    check("ws_addr_d", dst_haddr, 32'h304);
    check("ws_rdy_d", src_hready_resp, 2'b01);
    check("ws_wdata_d", dst_hwdata, 32'h33);
    tick();
    #1;
    check("ws_rdy_e", src_hready_resp, 2'b11);
    check("ws_wdata_e", dst_hwdata, 32'h34);
    tick();
    cfg_wait_en = 1'b0;
    check("ws_mem0", mem[8'hc0], 32'h33);
    check("ws_mem1", mem[8'hc1], 32'h34);

    // Two-cycle ERROR to port 1
    cfg_err_en = 1'b1;
    set_ap(1, NSEQ, 1'b1, 32'h3f0, 1'b0); #1;
    tick();
    set_wd(1, 32'h55); set_ap(1, IDLE, 1'b0, 32'h0, 1'b0); #1;
    check("err_hresp_1", src_hresp, 2'b10);
    check("err_rdy_1", src_hready_resp, 2'b01);
    tick();
    #1;
    check("err_hresp_2", src_hresp, 2'b10);
    check("err_rdy_2", src_hready_resp, 2'b11);
    tick();
    cfg_err_en = 1'b0;
    #1;
    check("err_hresp_3", src_hresp, 2'b00);
    check("err_nowrite", mem[8'hfc], 32'h0);
    tick();

    // Reset while port 1 is buffered
    set_ap(0, NSEQ, 1'b1, 32'h1f0, 1'b0); set_ap(1, NSEQ, 1'b1, 32'h1f4, 1'b0); #1;
    tick();
    set_ap(0, IDLE, 1'b0, 32'h0, 1'b0); set_ap(1, IDLE, 1'b0, 32'h0, 1'b0); #1;
    check("rb_buffered", dst_htrans, NSEQ);
    rst = 1'b1; #1;
    check("rb_htrans", dst_htrans, IDLE);
    check("rb_rdy", src_hready_resp, 2'b11);
    check("rb_haddr", dst_haddr, 32'h0);
    tick(); tick();
    rst = 1'b0; #1;
    check("rb_post_idle", dst_htrans, IDLE);
    check("rb_post_rdy", src_hready_resp, 2'b11);
    tick();
    set_ap(0, NSEQ, 1'b1, 32'h8, 1'b0); #1;
    check("rb_wr_addr", dst_haddr, 32'h8);
    tick();
    set_wd(0, 32'h88); set_ap(0, NSEQ, 1'b0, 32'h8, 1'b0); #1;
    check("rb_wr_rdy", src_hready_resp[0], 1'b1);
    tick();
    set_ap(0, IDLE, 1'b0, 32'h0, 1'b0); #1;
    check("rb_rdata", src_hrdata[31:0], 32'h88);
    check("rb_hready_mirror", dst_hready, dst_hready_resp);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahbl_arbiter.md
Name: ahbl_arbiter

Overview:
- N-master to 1-slave AHB-Lite arbiter. It is the counterpart of ahbl_splitter.
- Lets several AHB-Lite masters share one downstream port (a splitter or an ahb_sync_sram). Typical masters: processor instruction port, data port, display DMA.
- Each upstream master sees a plain AHB-Lite slave. Losing masters are stalled through their hready_resp while their address phase is buffered inside the arbiter.

Parameters:
- N_PORTS, 2, number of upstream master ports; port 0 has the highest priority.
- W_ADDR, 32, address width.
- W_DATA, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- src_hready  in  N_PORTS  per-port bus hready, normally tied to src_hready_resp
- src_hready_resp  out  N_PORTS  per-port data-phase ready to master
- src_hresp  out  N_PORTS  per-port error response
- src_haddr  in  N_PORTS*W_ADDR  addresses; port i at [i*W_ADDR +: W_ADDR]; same packing for all vectors
- src_hwrite  in  N_PORTS
- src_htrans  in  N_PORTS*2
- src_hsize  in  N_PORTS*3
- src_hburst  in  N_PORTS*3
- src_hprot  in  N_PORTS*4
- src_hmastlock  in  N_PORTS
- src_hwdata  in  N_PORTS*W_DATA
- src_hrdata  out  N_PORTS*W_DATA  broadcast of dst_hrdata
- dst_hready  out  1  equals dst_hready_resp
- dst_hready_resp  in  1  slave ready
- dst_hresp  in  1  slave error
- dst_haddr/hwrite/htrans/hsize/hburst/hprot/hmastlock  out  single-port widths  granted address phase
- dst_hwdata  out  W_DATA  write data from the data-phase owner
- dst_hrdata  in  W_DATA

Behaviour:
- **Reset (rst high, async):**
  - Clears buf_valid, the data-phase owner (dp_valid=0) and the lock owner.
  - Outputs: src_hready_resp all 1, src_hresp 0, dst_htrans IDLE (2'b00), remaining dst address outputs 0.
- **Request:** req[i] = buf_valid[i] | (src_hready[i] & src_htrans[i][1] & !stalled[i]).
- **Arbitration:**
  - Evaluated combinationally every cycle; takes effect only when dst_hready_resp=1.
  - Fixed priority: lowest active index wins.
  - If lock_owner is valid, only the lock owner may be granted. lock_owner is set when a granted transfer has hmastlock=1, and cleared when the lock owner is granted a transfer with hmastlock=0 or presents IDLE.
  - A lock owner that presents IDLE/BUSY still holds the grant and forwards its htrans.
- **Grant source:**
  - Granted port with buf_valid set: dst address outputs come from that port's buffer.
  - Otherwise they come straight from the src_* inputs (zero-cycle pass-through).
  - No grant: dst_htrans=IDLE.
- **Buffering:**
  - An active request sampled (src_hready[i]=1, htrans active) but not granted while dst_hready_resp=1 is registered into buf[i] (haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock) and buf_valid[i] is set.
  - A request also buffers if dst_hready_resp=0 at the sampling edge.
  - buf_valid[i] clears at the edge where buf[i] is granted with dst_hready_resp=1.
- **Stalled ports:** stalled[i] is set from the buffering edge until the data phase of the buffered transfer completes. While stalled: src_hready_resp[i]=0 and src_hresp[i]=0.
- **Data phase:**
  - At each edge with dst_hready_resp=1: dp_port <= granted port, dp_valid <= (granted htrans active).
  - dst_hwdata = src_hwdata[dp_port].
  - src_hready_resp[dp_port] = dst_hready_resp and src_hresp[dp_port] = dst_hresp. Two-cycle error responses pass through unchanged.
  - Ports neither stalled nor in data phase: src_hready_resp=1, src_hresp=0.
- **Ordering:** at most one buffered transfer per port. A master cannot issue again until its stall clears.
- **Simultaneous events:**
  - A port in data phase whose next request loses arbitration in the same cycle goes straight from dp owner to stalled; src_hready_resp is the dst value that cycle, 0 afterwards.
  - SEQ beats from the granted port keep priority only under hmastlock; bursts are otherwise re-arbitrated per beat.
- **Reset mid-transfer:** all buffered requests are discarded; dst_htrans goes IDLE immediately (async).
- Throughput: one transfer per cycle to the slave with zero wait states. A buffered transfer adds exactly one stall cycle per loss of arbitration.

Test Plan:
- Port 0 only: write 0xdeadbeef to 0x40, read 0x40 via 1-cycle SRAM → rdata 0xdeadbeef, src_hready_resp[0] never 0.
- Ports 0 and 1 issue NSEQ write in the same cycle (0x0, 0x100) → port 0 passes through. Port 1 is buffered, issued to dst the next cycle, sees src_hready_resp[1]=0 for 1 cycle. Both words read back correctly.
- Port 1 holds hmastlock=1 across 3 transfers while port 0 requests continuously → dst carries port 1 for all 3 transfers; port 0 is granted the cycle after port 1 drops the lock.
- Slave inserts 2 wait states on port 0's data phase while port 1 requests → port 1 is buffered and its address held stable on dst until dst_hready_resp=1, then it completes.
- Slave returns a 2-cycle ERROR to port 1 → src_hresp[1] is high for 2 cycles; src_hready_resp[1] is 0 then 1; port 0 sees hresp=0.
- Assert rst with buf_valid[1]=1 → dst_htrans=0 and src_hready_resp=all ones immediately; after release, a port 0 write to 0x8 completes normally.
